// File: rtl/pong_score_keeper.sv
// Two-player BCD score keeper for Motion-Pong: edge-detected point inputs,
// win detection, and a game-over hold with a blink strobe for the winner.
module pong_score_keeper #(
   parameter int WIN_SCORE    = 11,
   parameter int BLINK_CYCLES = 25000000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       point_p1,
   input  logic       point_p2,
   input  logic       new_game,
   output logic [3:0] p1_tens,
   output logic [3:0] p1_ones,
   output logic [3:0] p2_tens,
   output logic [3:0] p2_ones,
   output logic       game_over,
   output logic       winner,
   output logic       blink_on
);

   localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);
   localparam logic [3:0] WIN_TENS = 4'(WIN_SCORE / 10);
   localparam logic [3:0] WIN_ONES = 4'(WIN_SCORE % 10);

   generate
      if (WIN_SCORE < 1 || WIN_SCORE > 99) begin : g_bad_win_score
         $error("pong_score_keeper: WIN_SCORE must be in 1..99");
      end
      if (BLINK_CYCLES < 1) begin : g_bad_blink_cycles
         $error("pong_score_keeper: BLINK_CYCLES must be >= 1");
      end
   endgenerate

   typedef enum logic {
      PLAYING   = 1'b0,
      GAME_OVER = 1'b1
   } state_t;

   state_t           state, state_n;
   logic             p1_q, p2_q;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       p1_tens_n, p1_ones_n, p2_tens_n, p2_ones_n;
   logic             game_over_n, winner_n, blink_on_n;
   logic [7:0]       p1_inc, p2_inc;
   logic             ev1, ev2;

   function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
      if (ones == 4'd9)
         return {tens + 4'd1, 4'd0};
      else
         return {tens, ones + 4'd1};
   endfunction

   assign ev1    = point_p1 & ~p1_q;
   assign ev2    = point_p2 & ~p2_q;
   assign p1_inc = bcd_inc(p1_tens, p1_ones);
   assign p2_inc = bcd_inc(p2_tens, p2_ones);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= PLAYING;
         p1_q      <= 1'b0;
         p2_q      <= 1'b0;
         cnt       <= '0;
         p1_tens   <= 4'd0;
         p1_ones   <= 4'd0;
         p2_tens   <= 4'd0;
         p2_ones   <= 4'd0;
         game_over <= 1'b0;
         winner    <= 1'b0;
         blink_on  <= 1'b1;
      end else begin
         state     <= state_n;
         p1_q      <= point_p1;
         p2_q      <= point_p2;
         cnt       <= cnt_n;
         p1_tens   <= p1_tens_n;
         p1_ones   <= p1_ones_n;
         p2_tens   <= p2_tens_n;
         p2_ones   <= p2_ones_n;
         game_over <= game_over_n;
         winner    <= winner_n;
         blink_on  <= blink_on_n;
      end
   end

   // Simultaneous events cancel; new_game overrides everything else.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      p1_tens_n   = p1_tens;
      p1_ones_n   = p1_ones;
      p2_tens_n   = p2_tens;
      p2_ones_n   = p2_ones;
      game_over_n = game_over;
      winner_n    = winner;
      blink_on_n  = blink_on;
      if (new_game) begin
         state_n     = PLAYING;
         cnt_n       = '0;
         p1_tens_n   = 4'd0;
         p1_ones_n   = 4'd0;
         p2_tens_n   = 4'd0;
         p2_ones_n   = 4'd0;
         game_over_n = 1'b0;
         winner_n    = 1'b0;
         blink_on_n  = 1'b1;
      end else begin
         case (state)
            PLAYING: begin
               if (ev1 && !ev2) begin
                  {p1_tens_n, p1_ones_n} = p1_inc;
                  if (p1_inc == {WIN_TENS, WIN_ONES}) begin
                     state_n     = GAME_OVER;
                     game_over_n = 1'b1;
                     winner_n    = 1'b0;
                     cnt_n       = '0;
                     blink_on_n  = 1'b1;
                  end
               end else if (ev2 && !ev1) begin
                  {p2_tens_n, p2_ones_n} = p2_inc;
                  if (p2_inc == {WIN_TENS, WIN_ONES}) begin
                     state_n     = GAME_OVER;
                     game_over_n = 1'b1;
                     winner_n    = 1'b1;
                     cnt_n       = '0;
                     blink_on_n  = 1'b1;
                  end
               end
            end
            GAME_OVER: begin
               if (cnt == CNT_LAST) begin
                  cnt_n      = '0;
                  blink_on_n = ~blink_on;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            default: state_n = PLAYING;
         endcase
      end
   end

endmodule

// File: tb/tb_pong_score_keeper.sv
// Randomized and directed scoreboard bench for pong_score_keeper against an
// integer-score reference model.
module tb_pong_score_keeper;

   localparam int WIN   = 11;
   localparam int BLINK = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       point_p1 = 1'b0, point_p2 = 1'b0, new_game = 1'b0;
   logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;
   logic       game_over, winner, blink_on;

   pong_score_keeper #(.WIN_SCORE(WIN), .BLINK_CYCLES(BLINK)) dut (
      .clk(clk), .resetn(resetn), .point_p1(point_p1), .point_p2(point_p2),
      .new_game(new_game), .p1_tens(p1_tens), .p1_ones(p1_ones),
      .p2_tens(p2_tens), .p2_ones(p2_ones), .game_over(game_over),
      .winner(winner), .blink_on(blink_on)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] p1t, p1o, p2t, p2o;
      logic       go, win, blink;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: plain integer scores, elapsed cycles since the win.
   int  m_s1 = 0, m_s2 = 0, m_n = 0;
   bit  m_over = 0, m_win = 0, m_q1 = 0, m_q2 = 0;
   bit  e1, e2;

   function automatic exp_t model_out();
      exp_t e;
      e.p1t   = 4'(m_s1 / 10);
      e.p1o   = 4'(m_s1 % 10);
      e.p2t   = 4'(m_s2 / 10);
      e.p2o   = 4'(m_s2 % 10);
      e.go    = m_over;
      e.win   = m_over ? m_win : 1'b0;
      e.blink = m_over ? (((m_n / BLINK) % 2) == 0) : 1'b1;
      return e;
   endfunction

   always @(posedge clk) begin
      if (!resetn) begin
         m_s1 = 0; m_s2 = 0; m_n = 0;
         m_over = 0; m_win = 0; m_q1 = 0; m_q2 = 0;
      end else begin
         e1 = point_p1 && !m_q1;
         e2 = point_p2 && !m_q2;
         m_q1 = point_p1;
         m_q2 = point_p2;
         if (new_game) begin
            m_s1 = 0; m_s2 = 0; m_n = 0; m_over = 0; m_win = 0;
         end else if (m_over) begin
            m_n++;
         end else if (e1 != e2) begin
            if (e1) m_s1++; else m_s2++;
            if (m_s1 == WIN || m_s2 == WIN) begin
               m_over = 1; m_win = e2; m_n = 0;
            end
         end
      end
      q.push_back(model_out());
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         chk("p1_tens", int'(p1_tens), int'(mon_e.p1t));
         chk("p1_ones", int'(p1_ones), int'(mon_e.p1o));
         chk("p2_tens", int'(p2_tens), int'(mon_e.p2t));
         chk("p2_ones", int'(p2_ones), int'(mon_e.p2o));
         chk("game_over", int'(game_over), int'(mon_e.go));
         chk("winner", int'(winner), int'(mon_e.win));
         chk("blink_on", int'(blink_on), int'(mon_e.blink));
      end
   end

   task automatic step(input bit a, input bit b, input bit g);
      @(negedge clk);
      point_p1 = a;
      point_p2 = b;
      new_game = g;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0);
   endtask

   task automatic pulse1();
      step(1, 0, 0);
      step(0, 0, 0);
   endtask

   task automatic pulse2();
      step(0, 1, 0);
      step(0, 0, 0);
   endtask

   // Reset asserted mid-cycle must clear outputs before the next clock edge.
   task automatic async_reset();
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("async_p1_tens", int'(p1_tens), 0);
      chk("async_p1_ones", int'(p1_ones), 0);
      chk("async_p2_tens", int'(p2_tens), 0);
      chk("async_p2_ones", int'(p2_ones), 0);
      chk("async_game_over", int'(game_over), 0);
      chk("async_winner", int'(winner), 0);
      chk("async_blink_on", int'(blink_on), 1);
      @(negedge clk);
      #2 resetn = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
      $fatal(1);
   end

   initial begin
      #2 resetn = 1'b0;
      repeat (3) @(negedge clk);
      #2 resetn = 1'b1;
      idle(10);

      pulse1();
      pulse2();
      async_reset();

      // Held input counts once, then carry 9 -> 10.
      repeat (20) step(1, 0, 0);
      step(0, 0, 0);
      repeat (9) pulse1();

      // Simultaneous events at 3:5.
      step(0, 0, 1);
      step(0, 0, 0);
      repeat (3) pulse1();
      repeat (5) pulse2();
      step(1, 1, 0);
      step(0, 0, 0);
      pulse2();

      // Player 2 wins from 10:10, scores frozen afterwards.
      step(0, 0, 1);
      step(0, 0, 0);
      repeat (10) begin
         pulse1();
         pulse2();
      end
      pulse2();
      idle(12);
      pulse1();
      pulse2();
      idle(3);

      // new_game beats a rising point_p1.
      step(1, 0, 1);
      repeat (3) step(1, 0, 0);
      step(0, 0, 0);
      pulse1();

      // Reset while blink_on is low.
      step(0, 0, 1);
      step(0, 0, 0);
      repeat (10) pulse1();
      step(1, 0, 0);
      step(0, 0, 0);
      idle(4);
      async_reset();
      pulse1();
      idle(2);

      repeat (3000) begin
         if ($urandom_range(0, 499) == 0) async_reset();
         step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 199) == 0);
      end
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pong_score_keeper.md
Name: pong_score_keeper

Overview:
- Registered two-player score keeper for Motion-Pong.
- Counts point events from the ball/collision logic as packed BCD digits. The four 4-bit digit outputs drive the four seven-segment decoder instances (HEX3..HEX0) directly.
- Detects the win condition and holds a game-over state with a blink strobe for the winner's digits until a new game is requested.

Parameters:
- WIN_SCORE, 11, score that ends the game; legal range 1..99, checked at elaboration.
- BLINK_CYCLES, 25000000, clock cycles per blink_on half-period in GAME_OVER (0.5 s at 50 MHz); must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- point_p1  in  1  player 1 scored; level, may stay high for many cycles.
- point_p2  in  1  player 2 scored; level, may stay high for many cycles.
- new_game  in  1  synchronous clear of scores and state; level.
- p1_tens  out  4  player 1 BCD tens digit (0..9).
- p1_ones  out  4  player 1 BCD ones digit (0..9).
- p2_tens  out  4  player 2 BCD tens digit.
- p2_ones  out  4  player 2 BCD ones digit.
- game_over  out  1  high while in GAME_OVER.
- winner  out  1  0 = player 1, 1 = player 2; meaningful only when game_over = 1.
- blink_on  out  1  blink phase for the winner's digits; 1 = show.

Behaviour:
- All outputs and internal registers are flops. Reset is asynchronous and active-low; deassertion is taken on a clock edge.
- Reset values:
  - All digits 0.
  - game_over 0, winner 0, blink_on 1.
  - State PLAYING, blink counter 0.
  - Edge-detect registers p1_q and p2_q = 0.
- Edge detection:
  - p1_q and p2_q register point_p1 and point_p2 every cycle in every state.
  - A scoring event is point_pX = 1 while pX_q = 0 at a clock edge.
  - A held-high input counts once; a new event needs the input to drop for at least one cycle.
- Latency: the digit update is visible immediately after the edge that samples the event (one-cycle registered latency).
- BCD increment:
  - If ones < 9: ones + 1.
  - If ones = 9: ones ← 0 and tens + 1.
  - Tens never exceeds 9 because WIN_SCORE ≤ 99.
- Simultaneous events: both players rising at the same edge means neither score changes. Both edge registers still update.
- State PLAYING:
  - On an event, increment the scorer.
  - If the incremented value equals WIN_SCORE:
    - At the same edge, go to GAME_OVER.
    - game_over ← 1.
    - winner ← scorer (0 for player 1, 1 for player 2).
    - blink counter ← 0, blink_on ← 1.
- State GAME_OVER:
  - Point events are ignored; scores are frozen.
  - The blink counter counts 0..BLINK_CYCLES-1. On terminal count it wraps to 0 and blink_on toggles.
  - With BLINK_CYCLES = 1, blink_on toggles every cycle.
- new_game (either state, highest priority over point events at the same edge):
  - All digits ← 0.
  - State ← PLAYING, game_over ← 0, winner ← 0.
  - blink_on ← 1, blink counter ← 0.
  - p1_q/p2_q still capture their inputs, so a point input already high during new_game is not counted afterwards.
  - Held new_game keeps everything cleared.
- blink_on stays 1 throughout PLAYING.
- Reset mid-game or during blink returns immediately (asynchronously) to the reset values above.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle: assert resetn = 0 mid-cycle, release, run 10 cycles with no inputs -> all digits 0, game_over 0, blink_on 1 throughout, and outputs cleared before the next clk edge.
- Held point: point_p1 high for 20 cycles, then low -> p1_ones = 1 after the first edge only, p2 unchanged; repeat 9 more pulses -> p1_tens = 1, p1_ones = 0 (9→10 carry).
- Simultaneous events: raise point_p1 and point_p2 on the same edge with scores at 3:5 -> scores stay 3:5; next single p2 pulse -> 3:6.
- Win by player 2 with WIN_SCORE = 11, BLINK_CYCLES = 4, score 10:10:
  - p2 pulse -> p2 = 1,1; game_over = 1 and winner = 1 on the same edge.
  - blink_on toggles every 4 cycles (1,1,1,1,0,0,0,0,1...).
  - Further p1/p2 pulses leave 10:11.
- new_game priority: in GAME_OVER, assert new_game together with a rising point_p1 -> all digits 0, game_over 0, winner 0, blink_on 1, p1 stays 0. Dropping new_game while point_p1 remains high still leaves p1 = 0.
- Reset mid-blink: during GAME_OVER with blink_on = 0, pulse resetn low -> all digits 0, game_over 0, blink_on 1 asynchronously. A subsequent p1 pulse gives p1_ones = 1.
